// File: rtl/jk_bank_driver_if.sv
// Request handshake plus latch-bank drive/feedback bundle for jk_bank_driver.
// The requester/bank side uses the master modport; the driver uses slave.
interface jk_bank_driver_if #(
   parameter int unsigned WIDTH = 4
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;
   logic             mode;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             en;
   logic             done;
   logic             err;

   modport master (
      output tgt_valid, tgt_data, mode, q_fb,
      input  tgt_ready, j, k, en, done, err
   );

   modport slave (
      input  tgt_valid, tgt_data, mode, q_fb,
      output tgt_ready, j, k, en, done, err
   );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK latches toward a requested pattern. One enable pulse
// per attempt, one settle cycle, then the fed-back q is compared against the
// target; up to two retries before flagging a sticky error.
module jk_bank_driver #(
   parameter int unsigned WIDTH = 4
) (
   input logic           clk,
   input logic           rst,
   jk_bank_driver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } state_t;

   localparam logic [1:0] RETRY_MAX = 2'd2;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] tgt_q,    tgt_d;
   logic [WIDTH-1:0] cur_q,    cur_d;
   logic             mode_q,   mode_d;
   logic [1:0]       retry_q,  retry_d;
   logic [WIDTH-1:0] j_q,      j_d;
   logic [WIDTH-1:0] k_q,      k_d;
   logic             en_q,     en_d;
   logic             done_q,   done_d;
   logic             err_q,    err_d;

   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] set_mask;
   logic [WIDTH-1:0] clr_mask;

   // State and output registers; reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         cur_q   <= '0;
         mode_q  <= 1'b0;
         retry_q <= '0;
         j_q     <= '0;
         k_q     <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         cur_q   <= cur_d;
         mode_q  <= mode_d;
         retry_q <= retry_d;
         j_q     <= j_d;
         k_q     <= k_d;
         en_q    <= en_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state, capture and excitation logic. The excitation is derived from
   // the values about to be captured (cur_d/tgt_d/mode_d) so that j/k/en land
   // in their registers on the same edge that enters DRIVE.
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      cur_d    = cur_q;
      mode_d   = mode_q;
      retry_d  = retry_q;
      err_d    = err_q;
      done_d   = 1'b0;
      en_d     = 1'b0;
      j_d      = '0;
      k_d      = '0;
      diff     = '0;
      set_mask = '0;
      clr_mask = '0;

      case (state_q)
         IDLE: begin
            if (bus.tgt_valid) begin
               tgt_d   = bus.tgt_data;
               mode_d  = bus.mode;
               cur_d   = bus.q_fb;
               err_d   = 1'b0;
               retry_d = '0;
               if (bus.tgt_data == bus.q_fb) begin
                  state_d = CHECK;
               end else begin
                  state_d = DRIVE;
               end
            end
         end
         DRIVE: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (bus.q_fb == tgt_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 2'd1;
               cur_d   = bus.q_fb;
               state_d = DRIVE;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == DRIVE) begin
         diff     = cur_d ^ tgt_d;
         set_mask = mode_d ? {WIDTH{1'b1}} : tgt_d;
         clr_mask = mode_d ? {WIDTH{1'b1}} : ~tgt_d;
         en_d     = 1'b1;
         j_d      = diff & set_mask;
         k_d      = diff & clr_mask;
      end
   end

   assign bus.tgt_ready = (state_q == IDLE) && !rst;
   assign bus.j         = j_q;
   assign bus.k         = k_q;
   assign bus.en        = en_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

   // Output invariants: done/err exclusive, enable confined to DRIVE.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(done_q && err_q));
         assert (!en_q || state_q == DRIVE);
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural 4-bit JK latch bank.
// Sample point "s" = negedge after the s-th rising edge following acceptance.
module tb_jk_bank_driver;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   jk_bank_driver_if #(.WIDTH(W)) bus ();

   jk_bank_driver #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // JK latch bank model
   logic [W-1:0] bank;
   logic         load;
   logic [W-1:0] load_val;
   logic         stuck0;

   function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                            input logic [W-1:0] jj,
                                            input logic [W-1:0] kk);
      logic [W-1:0] r;
      r = q;
      for (int i = 0; i < int'(W); i++) begin
         case ({jj[i], kk[i]})
            2'b01:   r[i] = 1'b0;
            2'b10:   r[i] = 1'b1;
            2'b11:   r[i] = ~q[i];
            default: r[i] = q[i];
         endcase
      end
      return r;
   endfunction

   // Bank updates while enabled; load preloads a starting pattern.
   always @(posedge clk) begin
      if (load)        bank <= load_val;
      else if (bus.en) bank <= jk_next(bank, bus.j, bus.k);
   end

   assign bus.q_fb = stuck0 ? (bank & 4'b1110) : bank;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_bank(input logic [W-1:0] v);
      load_val = v;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   // Present a request at a negedge; returns at sample point s=0.
   task automatic accept(input logic [W-1:0] t, input logic m, input logic hold);
      bus.tgt_data  = t;
      bus.mode      = m;
      bus.tgt_valid = 1'b1;
      check_eq("ready_before_accept", bus.tgt_ready, 1);
      step();
      if (!hold) bus.tgt_valid = 1'b0;
   endtask

   int en_cnt;
   int done_cnt;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;
      bus.mode      = 1'b0;
      load          = 1'b0;
      load_val      = '0;
      stuck0        = 1'b0;

      // Reset state
      step();
      step();
      check_eq("rst_ready", bus.tgt_ready, 0);
      check_eq("rst_en",    bus.en,   0);
      check_eq("rst_j",     bus.j,    0);
      check_eq("rst_k",     bus.k,    0);
      check_eq("rst_done",  bus.done, 0);
      check_eq("rst_err",   bus.err,  0);
      rst = 1'b0;
      #1;
      check_eq("ready_after_rst", bus.tgt_ready, 1);

      // Set/reset excitation: 0000 -> 1010
      load_bank(4'b0000);
      accept(4'b1010, 1'b0, 1'b0);
      bus.tgt_data = 4'hF;
      bus.mode     = 1'b1;
      check_eq("s1_en",    bus.en, 1);
      check_eq("s1_j",     bus.j,  4'b1010);
      check_eq("s1_k",     bus.k,  4'b0000);
      check_eq("s1_busy",  bus.tgt_ready, 0);
      step();
      check_eq("s1_settle_en", bus.en, 0);
      check_eq("s1_settle_j",  bus.j,  0);
      check_eq("s1_settle_k",  bus.k,  0);
      step();
      check_eq("s1_check_done", bus.done, 0);
      step();
      check_eq("s1_done",  bus.done, 1);
      check_eq("s1_qfb",   bus.q_fb, 4'b1010);
      check_eq("s1_err",   bus.err,  0);
      check_eq("s1_ready", bus.tgt_ready, 1);
      step();
      check_eq("s1_done_pulse", bus.done, 0);

      // Toggle excitation: 1100 -> 0110
      load_bank(4'b1100);
      accept(4'b0110, 1'b1, 1'b0);
      check_eq("s2_en", bus.en, 1);
      check_eq("s2_j",  bus.j,  4'b1010);
      check_eq("s2_k",  bus.k,  4'b1010);
      step();
      step();
      step();
      check_eq("s2_done", bus.done, 1);
      check_eq("s2_qfb",  bus.q_fb, 4'b0110);

      // Already matching: no drive
      load_bank(4'b0101);
      accept(4'b0101, 1'b0, 1'b0);
      check_eq("s3_en0",    bus.en,   0);
      check_eq("s3_done0",  bus.done, 0);
      check_eq("s3_ready0", bus.tgt_ready, 0);
      step();
      check_eq("s3_en1",   bus.en,   0);
      check_eq("s3_done1", bus.done, 1);

      // Stuck bit: retries exhausted
      stuck0 = 1'b1;
      load_bank(4'b0000);
      accept(4'b0001, 1'b0, 1'b0);
      en_cnt   = 0;
      done_cnt = 0;
      for (int s = 0; s < 10; s++) begin
         if (s > 0) step();
         en_cnt   += int'(bus.en);
         done_cnt += int'(bus.done);
         if (s == 8) check_eq("s4_err_before", bus.err, 0);
      end
      check_eq("s4_err_set",   bus.err, 1);
      check_eq("s4_en_pulses", en_cnt,  3);
      check_eq("s4_no_done",   done_cnt, 0);
      step();
      check_eq("s4_err_sticky", bus.err, 1);
      accept(4'b0000, 1'b0, 1'b0);
      check_eq("s4_err_cleared", bus.err, 0);
      check_eq("s4_no_drive",    bus.en,  0);
      step();
      check_eq("s4_done_after", bus.done, 1);
      stuck0 = 1'b0;

      // Reset during SETTLE
      load_bank(4'b0000);
      accept(4'b0011, 1'b0, 1'b0);
      check_eq("s5_drive_en", bus.en, 1);
      step();
      check_eq("s5_settle_en", bus.en, 0);
      rst = 1'b1;
      #1;
      check_eq("s5_ready_in_rst", bus.tgt_ready, 0);
      step();
      check_eq("s5_en",    bus.en,   0);
      check_eq("s5_j",     bus.j,    0);
      check_eq("s5_k",     bus.k,    0);
      check_eq("s5_done",  bus.done, 0);
      check_eq("s5_err",   bus.err,  0);
      check_eq("s5_ready_rst", bus.tgt_ready, 0);
      rst = 1'b0;
      #1;
      check_eq("s5_ready_after", bus.tgt_ready, 1);
      for (int s = 0; s < 3; s++) begin
         step();
         check_eq("s5_no_done", bus.done, 0);
      end

      // Valid held high: back-to-back acceptance in the done cycle
      load_bank(4'b0000);
      accept(4'b0001, 1'b0, 1'b1);
      check_eq("s6_en_a", bus.en, 1);
      check_eq("s6_j_a",  bus.j,  4'b0001);
      bus.tgt_data = 4'b0011;
      step();
      check_eq("s6_settle_ready", bus.tgt_ready, 0);
      check_eq("s6_settle_en",    bus.en, 0);
      step();
      check_eq("s6_check_ready", bus.tgt_ready, 0);
      check_eq("s6_check_en",    bus.en, 0);
      step();
      check_eq("s6_done_a",  bus.done, 1);
      check_eq("s6_ready_a", bus.tgt_ready, 1);
      step();
      check_eq("s6_en_b",   bus.en,   1);
      check_eq("s6_j_b",    bus.j,    4'b0010);
      check_eq("s6_k_b",    bus.k,    4'b0000);
      check_eq("s6_done_b0", bus.done, 0);
      bus.tgt_valid = 1'b0;
      step();
      step();
      step();
      check_eq("s6_done_b", bus.done, 1);
      check_eq("s6_qfb_b",  bus.q_fb, 4'b0011);
      step();
      check_eq("s6_idle_ready", bus.tgt_ready, 1);
      check_eq("s6_idle_en",    bus.en,   0);
      check_eq("s6_idle_done",  bus.done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
